// File: rtl/jtkicker_video_pkg.sv
// rtl/jtkicker_video_pkg.sv - shared video timing constants and count type
//
// Purpose: default raster geometry for the video timer and the 9-bit
// counter type used by the timer and its window decoder.
// Ports: none (package).
package jtkicker_video_pkg;

    localparam int CNT_W = 9;

    typedef logic [CNT_W-1:0] count_t;

    localparam int DEF_HTOTAL   = 384;
    localparam int DEF_VTOTAL   = 264;
    localparam int DEF_HB_START = 256;
    localparam int DEF_HB_END   = 0;
    localparam int DEF_HS_START = 304;
    localparam int DEF_HS_END   = 336;
    localparam int DEF_VB_START = 240;
    localparam int DEF_VB_END   = 16;
    localparam int DEF_VS_START = 248;
    localparam int DEF_VS_END   = 256;

endpackage

// File: rtl/jtkicker_vtimer_win.sv
// rtl/jtkicker_vtimer_win.sv - combinational [s,e) window decoder
//
// Purpose: reports whether count x lies inside the half-open window [s,e).
// A window with s>e wraps through zero; s==e is an empty window.
// Ports:
//   x      in  count value under test
//   s      in  first value inside the window
//   e      in  first value past the window
//   active out 1 when x is inside the window
module jtkicker_vtimer_win
    import jtkicker_video_pkg::*;
(
    input  count_t x,
    input  count_t s,
    input  count_t e,
    output logic   active
);

    always_comb begin
        active = 1'b0;
        if (s < e) begin
            active = (x >= s) && (x < e);
        end else if (s > e) begin
            active = (x >= s) || (x < e);
        end
    end

endmodule

// File: rtl/jtkicker_vtimer.sv
// rtl/jtkicker_vtimer.sv - video raster timer: counters, blanking, syncs, strobes
//
// Purpose: advances h/v on each pixel clock enable and produces registered
// blanking/sync flags aligned with the counters plus single-clock strobes.
// Ports:
//   clk      in  video clock
//   rst      in  synchronous reset, active high
//   pxl_cen  in  pixel clock enable, one clk wide
//   h, v     out horizontal / vertical counts
//   hinit    out pulse when h becomes 0
//   vinit    out pulse when h and v both become 0
//   lhbl     out horizontal blank, active low
//   lvbl     out vertical blank, active low
//   hs, vs   out horizontal / vertical sync, active high
//   vint     out pulse when v becomes VB_START
module jtkicker_vtimer
    import jtkicker_video_pkg::*;
#(
    parameter int HTOTAL   = DEF_HTOTAL,
    parameter int VTOTAL   = DEF_VTOTAL,
    parameter int HB_START = DEF_HB_START,
    parameter int HB_END   = DEF_HB_END,
    parameter int HS_START = DEF_HS_START,
    parameter int HS_END   = DEF_HS_END,
    parameter int VB_START = DEF_VB_START,
    parameter int VB_END   = DEF_VB_END,
    parameter int VS_START = DEF_VS_START,
    parameter int VS_END   = DEF_VS_END
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pxl_cen,
    output logic [CNT_W-1:0] h,
    output logic [CNT_W-1:0] v,
    output logic             hinit,
    output logic             vinit,
    output logic             lhbl,
    output logic             lvbl,
    output logic             hs,
    output logic             vs,
    output logic             vint
);

    if (HTOTAL < 1 || HTOTAL > 512 || VTOTAL < 1 || VTOTAL > 512) begin : g_bad_total
        $error("jtkicker_vtimer: HTOTAL/VTOTAL must be in 1..512");
    end
    if (HB_START >= HTOTAL || HB_END >= HTOTAL || HS_START >= HTOTAL || HS_END >= HTOTAL ||
        HB_START < 0 || HB_END < 0 || HS_START < 0 || HS_END < 0) begin : g_bad_h
        $error("jtkicker_vtimer: horizontal window edges must be below HTOTAL");
    end
    if (VB_START >= VTOTAL || VB_END >= VTOTAL || VS_START >= VTOTAL || VS_END >= VTOTAL ||
        VB_START < 0 || VB_END < 0 || VS_START < 0 || VS_END < 0) begin : g_bad_v
        $error("jtkicker_vtimer: vertical window edges must be below VTOTAL");
    end

    localparam count_t H_MAX = count_t'(HTOTAL - 1);
    localparam count_t V_MAX = count_t'(VTOTAL - 1);

    count_t h_q, h_d, v_q, v_d;
    logic   lhbl_q, lvbl_q, hs_q, vs_q;
    logic   hinit_q, vinit_q, vint_q;
    logic   h_wrap, v_wrap;
    logic   hb_act, hs_act, vb_act, vs_act;

    always_comb begin
        h_wrap = (h_q == H_MAX);
        v_wrap = (v_q == V_MAX);
        h_d    = h_wrap ? '0 : h_q + 1'b1;
        v_d    = v_q;
        if (h_wrap) begin
            v_d = v_wrap ? '0 : v_q + 1'b1;
        end
    end

    // Flags are decoded from the next count so they land in the same
    // register update as the counter they describe.
    jtkicker_vtimer_win u_hb (.x(h_d), .s(count_t'(HB_START)), .e(count_t'(HB_END)), .active(hb_act));
    jtkicker_vtimer_win u_hs (.x(h_d), .s(count_t'(HS_START)), .e(count_t'(HS_END)), .active(hs_act));
    jtkicker_vtimer_win u_vb (.x(v_d), .s(count_t'(VB_START)), .e(count_t'(VB_END)), .active(vb_act));
    jtkicker_vtimer_win u_vs (.x(v_d), .s(count_t'(VS_START)), .e(count_t'(VS_END)), .active(vs_act));

    always_ff @(posedge clk) begin
        if (rst) begin
            h_q     <= '0;
            v_q     <= '0;
            lhbl_q  <= 1'b0;
            lvbl_q  <= 1'b0;
            hs_q    <= 1'b0;
            vs_q    <= 1'b0;
            hinit_q <= 1'b0;
            vinit_q <= 1'b0;
            vint_q  <= 1'b0;
        end else if (pxl_cen) begin
            h_q     <= h_d;
            v_q     <= v_d;
            lhbl_q  <= ~hb_act;
            lvbl_q  <= ~vb_act;
            hs_q    <= hs_act;
            vs_q    <= vs_act;
            hinit_q <= h_wrap;
            vinit_q <= h_wrap && v_wrap;
            vint_q  <= h_wrap && (v_d == count_t'(VB_START));
        end else begin
            hinit_q <= 1'b0;
            vinit_q <= 1'b0;
            vint_q  <= 1'b0;
        end
    end

    assign h     = h_q;
    assign v     = v_q;
    assign lhbl  = lhbl_q;
    assign lvbl  = lvbl_q;
    assign hs    = hs_q;
    assign vs    = vs_q;
    assign hinit = hinit_q;
    assign vinit = vinit_q;
    assign vint  = vint_q;

endmodule

// File: tb/tb_jtkicker_vtimer.sv
// tb/tb_jtkicker_vtimer.sv - scoreboard bench for jtkicker_vtimer
module tb_jtkicker_vtimer;

    // Three instances: A = default timing, B = short lines with default
    // vertical timing (whole frames fit in the run), C = empty hs/vb windows.
    localparam int HT  [3] = '{384, 24, 20};
    localparam int VT  [3] = '{264, 264, 12};
    localparam int HBS [3] = '{256, 16, 4};
    localparam int HBE [3] = '{0, 2, 12};
    localparam int HSS [3] = '{304, 18, 10};
    localparam int HSE [3] = '{336, 21, 10};
    localparam int VBS [3] = '{240, 240, 5};
    localparam int VBE [3] = '{16, 16, 5};
    localparam int VSS [3] = '{248, 248, 8};
    localparam int VSE [3] = '{256, 256, 2};

    typedef struct packed {
        logic [8:0] h;
        logic [8:0] v;
        logic       hinit;
        logic       vinit;
        logic       lhbl;
        logic       lvbl;
        logic       hs;
        logic       vs;
        logic       vint;
    } out_t;

    typedef struct packed {
        logic [1:0] dut;
        out_t       val;
    } exp_t;

    logic clk;
    logic rst;
    logic pxl_cen;
    logic [8:0] h_o [3];
    logic [8:0] v_o [3];
    logic hinit_o [3], vinit_o [3], lhbl_o [3], lvbl_o [3], hs_o [3], vs_o [3], vint_o [3];
    out_t act [3];

    for (genvar d = 0; d < 3; d++) begin : g_dut
        jtkicker_vtimer #(
            .HTOTAL(HT[d]), .VTOTAL(VT[d]),
            .HB_START(HBS[d]), .HB_END(HBE[d]),
            .HS_START(HSS[d]), .HS_END(HSE[d]),
            .VB_START(VBS[d]), .VB_END(VBE[d]),
            .VS_START(VSS[d]), .VS_END(VSE[d])
        ) u_dut (
            .clk(clk), .rst(rst), .pxl_cen(pxl_cen),
            .h(h_o[d]), .v(v_o[d]),
            .hinit(hinit_o[d]), .vinit(vinit_o[d]),
            .lhbl(lhbl_o[d]), .lvbl(lvbl_o[d]),
            .hs(hs_o[d]), .vs(vs_o[d]), .vint(vint_o[d])
        );
        assign act[d] = {h_o[d], v_o[d], hinit_o[d], vinit_o[d], lhbl_o[d],
                         lvbl_o[d], hs_o[d], vs_o[d], vint_o[d]};
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t sb [$];
    int   mh [3];
    int   mv [3];
    out_t mout [3];

    int a_cen = 0;
    bit a_first = 0;
    bit freeze_on = 0;
    int freeze_pulses = 0;
    int b_cen = 0;
    int b_last_vinit = 0;
    int b_vint_cnt = 0;
    int b_frames = 0;
    bit c_live = 0;
    int c_hs = 0;
    int c_vb = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit in_win(input int x, input int s, input int e);
        if (s < e) return (x >= s) && (x < e);
        if (s > e) return (x >= s) || (x < e);
        return 1'b0;
    endfunction

    task automatic model_step(input int d, input logic cen, input logic r);
        int nh, nv;
        bit hw, vw;
        if (r) begin
            mh[d]   = 0;
            mv[d]   = 0;
            mout[d] = '0;
        end else if (cen) begin
            hw = (mh[d] == HT[d] - 1);
            vw = (mv[d] == VT[d] - 1);
            nh = hw ? 0 : mh[d] + 1;
            nv = hw ? (vw ? 0 : mv[d] + 1) : mv[d];
            mout[d].h     = 9'(nh);
            mout[d].v     = 9'(nv);
            mout[d].hinit = hw;
            mout[d].vinit = hw && vw;
            mout[d].lhbl  = !in_win(nh, HBS[d], HBE[d]);
            mout[d].lvbl  = !in_win(nv, VBS[d], VBE[d]);
            mout[d].hs    = in_win(nh, HSS[d], HSE[d]);
            mout[d].vs    = in_win(nv, VSS[d], VSE[d]);
            mout[d].vint  = hw && (nv == VBS[d]);
            mh[d] = nh;
            mv[d] = nv;
        end else begin
            mout[d].hinit = 1'b0;
            mout[d].vinit = 1'b0;
            mout[d].vint  = 1'b0;
        end
    endtask

    task automatic tick(input logic cen, input logic r);
        exp_t e;
        string nm;
        pxl_cen = cen;
        rst     = r;
        for (int d = 0; d < 3; d++) begin
            model_step(d, cen, r);
            sb.push_back('{dut: 2'(d), val: mout[d]});
        end
        @(posedge clk);
        #1;
        while (sb.size() > 0) begin
            e  = sb.pop_front();
            nm = $sformatf("dut%0d_outputs", e.dut);
            check(nm, 32'(act[e.dut]), 32'(e.val));
        end
        // A: index of the first hinit since reset
        if (r) a_cen = 0;
        else if (cen) begin
            a_cen++;
            if (act[0].hinit && !a_first) begin
                check("cens_before_first_hinit", a_cen - 1, 383);
                a_first = 1;
            end
        end
        if (freeze_on && (act[0].hinit || act[0].vinit || act[0].vint)) freeze_pulses++;
        // B: frame length, vint position and count per frame
        if (r) begin
            b_cen = 0; b_last_vinit = 0; b_vint_cnt = 0;
        end else if (cen) begin
            b_cen++;
            if (act[1].vint) begin
                b_vint_cnt++;
                check("b_vint_position", {act[1].h, act[1].v}, {9'd0, 9'd240});
            end
            if (act[1].vinit) begin
                check("b_frame_cens", b_cen - b_last_vinit, 24 * 264);
                check("b_vint_per_frame", b_vint_cnt, 1);
                b_last_vinit = b_cen;
                b_vint_cnt = 0;
                b_frames++;
            end
        end
        // C: empty windows must never assert
        if (r) c_live = 0;
        else if (cen) c_live = 1;
        if (c_live) begin
            if (act[2].hs) c_hs++;
            if (!act[2].lvbl) c_vb++;
        end
    endtask

    task automatic run_to(input int d, input int th, input int tv);
        int n = 0;
        while (!(mh[d] == th && mv[d] == tv) && n < 90000) begin
            tick(1'b1, 1'b0);
            n++;
        end
        if (!(mh[d] == th && mv[d] == tv)) check("run_to_budget", 0, 1);
    endtask

    initial begin
        int lo, hi, hs_first, hb_first;
        rst = 1'b1;
        pxl_cen = 1'b0;
        for (int d = 0; d < 3; d++) begin
            mh[d] = 0; mv[d] = 0; mout[d] = '0;
        end
        repeat (3) tick(1'b0, 1'b1);
        tick(1'b1, 1'b1);
        check("reset_state_a", 32'(act[0]), 32'd0);

        // pxl_cen every 8 clk through the first line wrap
        repeat (400) begin
            tick(1'b1, 1'b0);
            repeat (7) tick(1'b0, 1'b0);
        end
        if (!a_first) check("first_hinit_seen", 0, 1);

        // one full default line
        run_to(0, 0, 2);
        lo = 0; hi = 0; hs_first = -1; hb_first = -1;
        repeat (384) begin
            tick(1'b1, 1'b0);
            if (!act[0].lhbl) begin
                lo++;
                if (hb_first < 0) hb_first = int'(act[0].h);
            end
            if (act[0].hs) begin
                hi++;
                if (hs_first < 0) hs_first = int'(act[0].h);
            end
        end
        check("line_lhbl_low_count", lo, 128);
        check("line_hs_high_count", hi, 32);
        check("line_lhbl_first_low_h", hb_first, 256);
        check("line_hs_first_high_h", hs_first, 304);

        // freeze with pxl_cen low
        run_to(0, 100, 50);
        freeze_on = 1;
        repeat (1000) tick(1'b0, 1'b0);
        freeze_on = 0;
        check("freeze_h", act[0].h, 100);
        check("freeze_v", act[0].v, 50);
        check("freeze_pulses", freeze_pulses, 0);
        tick(1'b1, 1'b0);
        check("resume_h", act[0].h, 101);

        // mid-frame reset without pxl_cen
        run_to(0, 200, 120);
        tick(1'b0, 1'b1);
        check("midreset_hv", {act[0].h, act[0].v}, 18'd0);
        check("midreset_flags", {act[0].lhbl, act[0].lvbl, act[0].hs, act[0].vs}, 4'd0);
        tick(1'b1, 1'b0);
        check("post_reset_h", act[0].h, 1);
        check("post_reset_flags", {act[0].lhbl, act[0].lvbl, act[0].hinit}, 3'b100);
        check("b_frames_seen", b_frames >= 2, 1);

        // two frames of instance C after reset
        repeat (2 * 20 * 12) tick(1'b1, 1'b0);
        check("c_hs_never_high", c_hs, 0);
        check("c_lvbl_never_low", c_vb, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
